// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO write- and read-side controllers.
// Contents:
//   PTR_MAX_W - widest pointer the helper functions handle
//   depth()   - FIFO depth for a given address width
//   bin2gray  - binary to reflected Gray, any width up to PTR_MAX_W
//   gray2bin  - reflected Gray to binary, any width up to PTR_MAX_W
// Pass narrower values zero-extended to 32 bits and size-cast the result back.
// Zero-extension is exact for both conversions because leading zeros map to
// leading zeros.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rr_arb.sv
// Combinational round-robin arbiter, shared by the FIFO write- and read-side
// controllers.
// Ports:
//   req     in  NUM_REQ  request vector
//   rr_ptr  in  IDX_W    index with the highest priority this cycle
//   enable  in  1        when low, no grant is issued
//   gnt     out NUM_REQ  one-hot grant, zero when nothing is granted
//   gnt_idx out IDX_W    index of the granted requester (0 when none)
module fifo_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  int idx;

  // Scan from the farthest offset down to rr_ptr itself. The last hit is
  // kept, so the closest asserted request at or after rr_ptr (with wrap) wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    if (enable) begin
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
        idx = int'(rr_ptr) + off;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
          gnt_idx  = IDX_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl_arb.sv
// Write-side controller of the async FIFO. It arbitrates round-robin among
// NUM_REQ writers for the single memory write port and owns the write pointer
// in binary and Gray form. Full, almost-full and fill level are derived from
// the read pointer after it has been synchronized into wclk.
// Ports:
//   wclk, wrst_n   write clock, asynchronous active-low reset
//   req, req_data  per-writer request level and data (writer i at [i*DATA_W +: DATA_W])
//   gnt            one-hot grant; the write happens on the wclk edge where it is high
//   wq2_rptr       Gray read pointer already synchronized to wclk
//   wptr           registered Gray write pointer, goes to the w2r synchronizer
//   waddr, wdata   memory write address and data, valid while wen=1
//   wen            memory write enable (|gnt)
//   wfull, walmost_full, wlevel  registered status seen from the write side
import fifo_pkg::*;

module fifo_wr_ctrl_arb #(
  parameter int ADDR_SIZE    = 4,
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int AFULL_THRESH = 12
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic [ADDR_SIZE:0]        wq2_rptr,
  output logic [ADDR_SIZE:0]        wptr,
  output logic [ADDR_SIZE-1:0]      waddr,
  output logic [DATA_W-1:0]         wdata,
  output logic                      wen,
  output logic                      wfull,
  output logic                      walmost_full,
  output logic [ADDR_SIZE:0]        wlevel
);

  localparam int A     = ADDR_SIZE;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [A:0]       wbin_reg;
  logic [A:0]       wbin_next;
  logic [A:0]       wgray_next;
  logic [A:0]       rbin;
  logic [A:0]       level_next;
  logic             full_next;
  logic             afull_next;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] rr_ptr_next;
  logic [IDX_W-1:0] gnt_idx;
  logic             arb_en;
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  // Gating with wrst_n keeps gnt/wen low while reset is held, even though
  // the arbiter itself is combinational.
  assign arb_en = ~wfull & wrst_n;

  fifo_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr_reg),
    .enable  (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_data
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign wen   = |gnt;
  assign wdata = data_arr[gnt_idx];
  assign waddr = wbin_reg[A-1:0];

  // The next pointer and the current synchronized read pointer are used
  // together, so a write and a read-pointer change in the same cycle stay
  // consistent.
  assign wbin_next  = wbin_reg + {{A{1'b0}}, wen};
  assign wgray_next = (A+1)'(bin2gray(32'(wbin_next)));
  assign rbin       = (A+1)'(gray2bin(32'(wq2_rptr)));
  assign level_next = wbin_next - rbin;

  // Full when the write pointer is exactly one lap ahead: the top two Gray
  // bits differ and the rest match.
  assign full_next  = (wgray_next == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]});
  assign afull_next = (level_next >= (A+1)'(AFULL_THRESH));

  assign rr_ptr_next = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_reg     <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      rr_ptr_reg   <= '0;
    end else begin
      wbin_reg     <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= full_next;
      walmost_full <= afull_next;
      wlevel       <= level_next;
      if (wen) rr_ptr_reg <= rr_ptr_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl_arb.sv
module tb_fifo_wr_ctrl_arb;

  localparam int AW    = 4;
  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int AFT   = 12;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;

  logic             wclk = 1'b0;
  logic             wrst_n;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic [AW:0]      wq2_rptr;
  logic [AW:0]      wptr;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic             wen;
  logic             wfull;
  logic             walmost_full;
  logic [AW:0]      wlevel;

  fifo_wr_ctrl_arb #(
    .ADDR_SIZE    (AW),
    .NUM_REQ      (NR),
    .DATA_W       (DW),
    .AFULL_THRESH (AFT)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .wq2_rptr     (wq2_rptr),
    .wptr         (wptr),
    .waddr        (waddr),
    .wdata        (wdata),
    .wen          (wen),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel)
  );

  always #5 wclk = ~wclk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: total words written / read as plain counters.
  int wr_cnt, rd_cnt;
  int m_rr;
  bit m_full;
  int last_win;
  int gcnt [NR];

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_rd(input int r);
    rd_cnt   = r;
    wq2_rptr = 5'(gray(r % PMOD));
  endtask

  task automatic model_reset();
    wr_cnt = 0; m_rr = 0; m_full = 0; last_win = -1;
    for (int i = 0; i < NR; i++) gcnt[i] = 0;
  endtask

  task automatic chk_regs(input string tag);
    int lvl;
    lvl = wr_cnt - rd_cnt;
    chk({tag, ".wptr"},  wptr, gray(wr_cnt % PMOD));
    chk({tag, ".wlevel"}, wlevel, lvl);
    chk({tag, ".wfull"}, wfull, (lvl == DEPTH) ? 1 : 0);
    chk({tag, ".wafull"}, walmost_full, (lvl >= AFT) ? 1 : 0);
  endtask

  // One clock: inputs already driven by caller.
  task automatic cycle(input string tag);
    int  win;
    int  i;
    logic [DW-1:0] d;
    logic [NR*DW-1:0] rd_snapshot;
    #1;
    win = -1;
    if (!m_full) begin
      for (int k = 0; k < NR; k++) begin
        i = (m_rr + k) % NR;
        if (win < 0 && req[i]) win = i;
      end
    end
    chk({tag, ".gnt"}, gnt, (win >= 0) ? (1 << win) : 0);
    chk({tag, ".wen"}, wen, (win >= 0) ? 1 : 0);
    if (win >= 0) begin
      rd_snapshot = req_data;
      d = rd_snapshot[win*DW +: DW];
      chk({tag, ".waddr"}, waddr, wr_cnt % DEPTH);
      chk({tag, ".wdata"}, wdata, d);
    end
    @(posedge wclk);
    if (win >= 0) begin
      wr_cnt++;
      m_rr = (win + 1) % NR;
      gcnt[win]++;
      last_win = win;
    end else begin
      last_win = -1;
    end
    m_full = ((wr_cnt - rd_cnt) == DEPTH);
    #1;
    chk_regs(tag);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    req    = '1;
    req_data = $urandom;
    set_rd(0);
    model_reset();
    #1;
    chk("rst.gnt", gnt, 0);
    chk("rst.wen", wen, 0);
    chk_regs("rst");
    @(posedge wclk);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    req = '0;
  endtask

  initial begin
    wrst_n   = 1'b1;
    req      = '0;
    req_data = '0;
    wq2_rptr = '0;
    model_reset();
    rd_cnt = 0;
    #2;
    do_reset();

    // Writer 0 alone fills the FIFO, then stays blocked.
    req = 4'b0001;
    for (int n = 0; n < 18; n++) begin
      req_data = $urandom;
      cycle("fill");
    end
    chk("fill.full_at16", wfull, 1);
    chk("fill.level16", wlevel, 16);

    // Read pointer advances by one: full clears one edge later, one more write fits.
    set_rd(1);
    req_data = $urandom;
    cycle("unfull");
    chk("unfull.wfull", wfull, 0);
    chk("unfull.wlevel", wlevel, 15);
    req_data = $urandom;
    cycle("refill");
    chk("refill.wfull", wfull, 1);

    // All writers on an empty FIFO.
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      req_data = $urandom;
      cycle("all4");
      chk("all4.order", last_win, n % NR);
    end

    // Pointer wrap: two laps with the read side catching up after each.
    do_reset();
    req = 4'b0001;
    for (int lap = 0; lap < 2; lap++) begin
      for (int n = 0; n < 16; n++) begin
        req_data = $urandom;
        cycle("wrap");
      end
      set_rd(wr_cnt);
      req_data = $urandom;
      req = 4'b0000;
      cycle("wrap.drain");
      req = 4'b0001;
      if (lap == 0) chk("wrap.msb", wptr[AW], 1);
    end
    chk("wrap.zero", wptr, 0);

    // Writers 1 and 3; writer 3 drops out after two grants.
    for (int k = 0; k < NR; k++) gcnt[k] = 0;
    req = 4'b1010;
    for (int n = 0; n < 10; n++) begin
      set_rd(wr_cnt);
      req_data = $urandom;
      cycle("w13");
      if (gcnt[3] >= 2) req = 4'b0010;
    end
    chk("w13.g0", gcnt[0], 0);
    chk("w13.g2", gcnt[2], 0);
    chk("w13.g3", gcnt[3], 2);

    // Random traffic, read side advancing by random amounts.
    for (int n = 0; n < 400; n++) begin
      req      = NR'($urandom);
      req_data = $urandom;
      if ($urandom_range(0, 2) == 0) set_rd(rd_cnt + $urandom_range(0, wr_cnt - rd_cnt));
      cycle("rand");
    end

    // Asynchronous reset mid-burst at level 9.
    do_reset();
    req = 4'b0001;
    for (int n = 0; n < 9; n++) begin
      req_data = $urandom;
      cycle("pre_rst");
    end
    chk("pre_rst.level9", wlevel, 9);
    #2;
    wrst_n = 1'b0;
    set_rd(0);
    model_reset();
    #1;
    chk("arst.gnt", gnt, 0);
    chk_regs("arst");
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    req = 4'b1111;
    req_data = $urandom;
    cycle("post_rst");
    chk("post_rst.first", last_win, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
